// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies an asynchronous PLL lock and then releases
// N_CH reset domains one at a time, STAGGER cycles apart.
// Losing lock at any point sends every domain back into reset.
module reset_sequencer #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 16,
   parameter int STRETCH     = 8,
   parameter int STAGGER     = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            locked,
   output logic [N_CH-1:0] rst_out,
   output logic            rst_done
);

   localparam int LAST_REL = (N_CH - 1) * STAGGER;
   localparam int MAX_AB   = (LOCK_FILTER > STRETCH) ? LOCK_FILTER : STRETCH;
   localparam int MAX_CNT  = (MAX_AB > LAST_REL) ? MAX_AB : LAST_REL;
   localparam int CW       = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] LF_LAST  = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] ST_LAST  = CW'(STRETCH);
   localparam logic [CW-1:0] REL_LAST = CW'(LAST_REL);

   localparam logic [1:0] WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_STRETCH = 2'd1;
   localparam logic [1:0] RELEASE   = 2'd2;
   localparam logic [1:0] RUN       = 2'd3;

   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;
   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_inc;

   assign lock_s  = sync[SYNC_STAGES-1];
   assign cnt_inc = cnt + 1'b1;

   // Lock synchroniser, lock filter, stretch and staggered release.
   // The terminal count of each phase is detected one edge early so the
   // transition lands on the edge the count would be reached.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync     <= '0;
         state    <= WAIT_LOCK;
         cnt      <= '0;
         rst_out  <= '1;
         rst_done <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], locked};
         if (state != WAIT_LOCK && !lock_s) begin
            // Lock lost after qualification: everything back into reset.
            state    <= WAIT_LOCK;
            cnt      <= '0;
            rst_out  <= '1;
            rst_done <= 1'b0;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  rst_out  <= '1;
                  rst_done <= 1'b0;
                  if (!lock_s) begin
                     cnt <= '0;
                  end else if (cnt == LF_LAST) begin
                     state <= ST_STRETCH;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               ST_STRETCH: begin
                  if (cnt == ST_LAST) begin
                     cnt        <= '0;
                     rst_out[0] <= 1'b0;
                     if (N_CH == 1) begin
                        // Single domain: the first release is also the last.
                        state    <= RUN;
                        rst_done <= 1'b1;
                     end else begin
                        state <= RELEASE;
                     end
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               RELEASE: begin
                  cnt <= cnt_inc;
                  for (int k = 1; k < N_CH; k++) begin
                     if (cnt_inc == CW'(k * STAGGER)) rst_out[k] <= 1'b0;
                  end
                  if (cnt_inc == REL_LAST) begin
                     state    <= RUN;
                     rst_done <= 1'b1;
                  end
               end
               default: begin
                  // RUN: hold until lock is lost or reset.
                  state <= RUN;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-domain instance and a 1-domain,
// STAGGER=1 instance share the same clk/reset/locked stimulus.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       locked;
   logic [2:0] rst_out;
   logic       rst_done;
   logic [0:0] rst_out1;
   logic       rst_done1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   reset_sequencer #(.N_CH(3), .SYNC_STAGES(2), .LOCK_FILTER(4), .STRETCH(3), .STAGGER(2)) dut (
      .clk(clk), .reset(reset), .locked(locked), .rst_out(rst_out), .rst_done(rst_done));

   reset_sequencer #(.N_CH(1), .SYNC_STAGES(2), .LOCK_FILTER(4), .STRETCH(3), .STAGGER(1)) dut1 (
      .clk(clk), .reset(reset), .locked(locked), .rst_out(rst_out1), .rst_done(rst_done1));

   // Expected {rst_done, rst_out} for the 3-domain instance, e = edges since
   // the first edge sampling locked=1 (edge 0).
   function automatic logic [3:0] nom3(int e);
      if (e < 9)  return 4'b0111;
      if (e < 11) return 4'b0110;
      if (e < 13) return 4'b0100;
      return 4'b1000;
   endfunction

   // Expected {rst_done, rst_out} for the single-domain instance.
   function automatic logic [1:0] nom1(int e);
      return (e < 9) ? 2'b01 : 2'b10;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, int e, logic [3:0] obs, logic [3:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
      end
   endtask

   task automatic chk_both(string tag, int e, logic [3:0] exp3, logic [1:0] exp1);
      chk({tag, "/ch3"}, e, {rst_done, rst_out}, exp3);
      chk({tag, "/ch1"}, e, {2'b00, rst_done1, rst_out1}, {2'b00, exp1});
   endtask

   // Advance edges first..last, checking against the nominal profile shifted.
   task automatic run(string tag, int first, int last, int shift);
      for (int e = first; e <= last; e++) begin
         tick();
         chk_both(tag, e, nom3(e - shift), nom1(e - shift));
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      locked = 1'b0;
      repeat (3) tick();
      chk_both("reset_state", 0, 4'b0111, 2'b01);

      // Power-up with no lock: everything stays in reset.
      reset = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         chk_both("no_lock", i, 4'b0111, 2'b01);
      end

      // Nominal release sequence.
      do_reset();
      locked = 1'b1;
      run("nominal", 0, 15, 0);

      // Lock loss in RUN: reset returns on the third edge after the drop.
      locked = 1'b0;
      tick(); chk_both("loss_e1", 1, 4'b1000, 2'b10);
      tick(); chk_both("loss_e2", 2, 4'b1000, 2'b10);
      tick(); chk_both("loss_e3", 3, 4'b0111, 2'b01);
      tick(); chk_both("loss_e4", 4, 4'b0111, 2'b01);
      tick(); chk_both("loss_e5", 5, 4'b0111, 2'b01);
      locked = 1'b1;
      run("relock", 0, 15, 0);

      // Reset at edge 10, mid-release, then a full restart with locked high.
      do_reset();
      run("pre_rst", 0, 9, 0);
      reset = 1'b1;
      tick();
      chk_both("rst_mid_rel", 10, 4'b0111, 2'b01);
      reset = 1'b0;
      run("post_rst", 0, 15, 0);

      // Reset on the edge that would release domain 0 wins.
      do_reset();
      run("pre_prio", 0, 8, 0);
      reset = 1'b1;
      tick();
      chk_both("rst_priority", 9, 4'b0111, 2'b01);
      reset = 1'b0;
      run("post_prio", 0, 10, 0);

      // One-cycle glitch during filtering restarts the filter.
      locked = 1'b0;
      repeat (4) tick();
      chk_both("glitch_idle", 0, 4'b0111, 2'b01);
      locked = 1'b1;
      run("glitch_pre", 0, 2, 0);
      locked = 1'b0;
      tick();
      chk_both("glitch_low", 3, 4'b0111, 2'b01);
      locked = 1'b1;
      run("glitch", 4, 17, 4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
